// File: rtl/score_board_nw_pkg.sv
// Shared types and constants for the N-issue scoreboard.
//   sb_data_t  : per-register entry {line, position, accept_mask}
//   reg_addr_t : architectural register address
//   bool_t     : single-bit flag
// position is one-hot (or zero); bit DEPTH-1 is the first post-issue stage (EX).
package score_board_nw_pkg;

  localparam int ISSUE_W    = 2;
  localparam int RP         = 4;
  localparam int DEPTH      = 3;
  localparam int NREG       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int LINE_W     = (ISSUE_W > 1) ? $clog2(ISSUE_W) : 1;

  localparam logic [DEPTH-1:0] FLUSH_STG = 3'b100;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic                  bool_t;

  typedef struct packed {
    logic [LINE_W-1:0] line;
    logic [DEPTH-1:0]  position;
    logic [DEPTH-1:0]  accept_mask;
  } sb_data_t;

  // Operand is usable when the producer has retired or sits in a bypassable stage.
  function automatic bool_t entry_ready(input sb_data_t e);
    return (e.position == '0) || ((e.position & e.accept_mask) != '0);
  endfunction

endpackage

// File: rtl/score_board_nw_entry.sv
// One architectural register's scoreboard entry and its update rule.
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   alloc       : a lane allocates this register this cycle (already qualified)
//   alloc_data  : entry value to load on allocation
//   flash       : pipeline flush; clears the entry if it sits in a FLUSH_STG stage
//   stall_mask  : bit k=1 holds a producer at position bit k
//   data        : current entry state
// Priority: rst > alloc > flush hit > advance.
module sb_entry
  import score_board_nw_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             alloc,
  input  sb_data_t         alloc_data,
  input  logic             flash,
  input  logic [DEPTH-1:0] stall_mask,
  output sb_data_t         data
);

  sb_data_t r_data;
  logic     w_flush_hit;
  logic     w_advance;

  assign w_flush_hit = flash && ((r_data.position & FLUSH_STG) != '0);
  // position is one-hot, so it moves only when its own stage is not stalled.
  assign w_advance   = (r_data.position & ~stall_mask) != '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_data <= '0;
    end else if (alloc) begin
      r_data <= alloc_data;
    end else if (w_flush_hit) begin
      r_data <= '0;
    end else if (w_advance) begin
      // Shifting out of bit 0 retires the producer; line/mask are left stale.
      r_data.position <= r_data.position >> 1;
    end
  end

  assign data = r_data;

endmodule

// File: rtl/score_board_nw.sv
// N-issue scoreboard: tracks which post-issue stage holds the youngest in-flight
// producer of each architectural register, and answers RP operand lookups.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   flash               : pipeline flush
//   stall               : issue stage stalled (blocks allocation)
//   post_is_stall_mask  : per-stage stall, bit k = position bit k
//   write_ena/addr      : per-lane allocation request and destination
//   write_accept_mask   : per-lane stages whose result may be bypassed
//   read_addr           : RP lookup addresses
//   data_out/read_ready : entry of read_addr and its ready verdict (combinational)
//   busy                : per-register "producer in flight"
// Handshake: none; allocations are fire-and-forget, reads are pure lookups of
// current state (a same-cycle allocation is visible only on the next cycle).
module score_board_nw
  import score_board_nw_pkg::*;
(
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              flash,
  input  logic                              stall,
  input  logic [DEPTH-1:0]                  post_is_stall_mask,
  input  logic [ISSUE_W-1:0]                write_ena,
  input  reg_addr_t [ISSUE_W-1:0]           write_addr,
  input  logic [ISSUE_W-1:0][DEPTH-1:0]     write_accept_mask,
  input  reg_addr_t [RP-1:0]                read_addr,
  output sb_data_t [RP-1:0]                 data_out,
  output logic [RP-1:0]                     read_ready,
  output logic [NREG-1:0]                   busy
);

  logic     [NREG-1:1] w_alloc;
  sb_data_t [NREG-1:1] w_alloc_data;
  sb_data_t [NREG-1:0] w_entries;

  // Lane priority encoder: later (higher) lanes overwrite earlier hits.
  always_comb begin
    w_alloc      = '0;
    w_alloc_data = '0;
    for (int r = 1; r < NREG; r++) begin
      for (int i = 0; i < ISSUE_W; i++) begin
        if (write_ena[i] && !stall && !flash &&
            (write_addr[i] == REG_ADDR_W'(r))) begin
          w_alloc[r]                  = 1'b1;
          w_alloc_data[r].line        = LINE_W'(i);
          w_alloc_data[r].position    = {1'b1, {(DEPTH-1){1'b0}}};
          w_alloc_data[r].accept_mask = write_accept_mask[i];
        end
      end
    end
  end

  // Register 0 is hardwired to an empty entry.
  assign w_entries[0] = '0;

  for (genvar g = 1; g < NREG; g++) begin : g_entry
    sb_entry u_entry (
      .clk        (clk),
      .rst        (rst),
      .alloc      (w_alloc[g]),
      .alloc_data (w_alloc_data[g]),
      .flash      (flash),
      .stall_mask (post_is_stall_mask),
      .data       (w_entries[g])
    );
  end

  always_comb begin
    data_out   = '0;
    read_ready = '0;
    for (int p = 0; p < RP; p++) begin
      data_out[p]   = w_entries[read_addr[p]];
      read_ready[p] = entry_ready(w_entries[read_addr[p]]);
    end
  end

  always_comb begin
    busy = '0;
    for (int r = 0; r < NREG; r++) begin
      busy[r] = (w_entries[r].position != '0);
    end
  end

endmodule
